handshake_pipe_chain: RTL and testbench

// - Valid/ready pipeline: PIP_NUM cascaded full-throughput register slices feeding an internal

---
 rtl/hs_pkg.sv | 10 +
 rtl/handshake_pip.sv | 72 +++++++
 rtl/handshake_pipe_chain.sv | 87 ++++++++
 tb/tb_handshake_pipe_chain.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared defaults for the valid/ready register-slice chain and its sink.
package hs_pkg;
    localparam int           DW_DEF        = 8;
    localparam int           PIP_NUM_DEF   = 5;
    localparam logic [7:0]   READY_PAT_DEF = 8'hFF;

    function automatic logic [7:0] rotate_right(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction
endpackage

// File: rtl/handshake_pip.sv
// One full-throughput register slice: main register plus a skid register so
// that s_ready is registered and does not depend combinationally on m_ready.
module handshake_pip
    import hs_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q,  main_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic          accept;
    logic          drain;

    assign s_ready = !skid_valid_q;
    assign m_valid = main_valid_q;
    assign m_data  = main_data_q;
    assign accept  = s_valid && !skid_valid_q;
    assign drain   = main_valid_q && m_ready;

    // A full skid blocks accept, so a drain either promotes the skid word or
    // takes the incoming word straight into main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (drain) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = s_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = s_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/handshake_pipe_chain.sv
// PIP_NUM cascaded register slices feeding a sink whose ready follows a
// rotating pattern; the sink reports each accepted word and a running count.
module handshake_pipe_chain
    import hs_pkg::*;
#(
    parameter int         DW        = DW_DEF,
    parameter int         PIP_NUM   = PIP_NUM_DEF,
    parameter logic [7:0] READY_PAT = READY_PAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          rx_valid,
    output logic [DW-1:0] rx_data,
    output logic [31:0]   rx_count
);

    logic          valid [PIP_NUM];
    logic          ready [PIP_NUM];
    logic [DW-1:0] data  [PIP_NUM];
    logic          d_s_ready;

    // ready[k] is the s_ready of slice k; slice k drains into slice k+1 or the sink.
    for (genvar k = 0; k < PIP_NUM; k++) begin : g_slice
        logic          upValid;
        logic [DW-1:0] upData;
        logic          downReady;

        if (k == 0) begin : g_head
            assign upValid = s_valid;
            assign upData  = s_data;
        end else begin : g_mid
            assign upValid = valid[k-1];
            assign upData  = data[k-1];
        end

        if (k == PIP_NUM - 1) begin : g_tail
            assign downReady = d_s_ready;
        end else begin : g_next
            assign downReady = ready[k+1];
        end

        handshake_pip #(.DW(DW)) u_pip (
            .clk     (clk),
            .rst     (rst),
            .s_valid (upValid),
            .s_ready (ready[k]),
            .s_data  (upData),
            .m_valid (valid[k]),
            .m_ready (downReady),
            .m_data  (data[k])
        );
    end

    assign s_ready = ready[0];

    logic [7:0]    pat_q;
    logic          rx_valid_q;
    logic [DW-1:0] rx_data_q;
    logic [31:0]   rx_count_q;
    logic          d_xfer;

    assign d_s_ready = pat_q[0];
    assign d_xfer    = valid[PIP_NUM-1] && d_s_ready;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_count  = rx_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q      <= READY_PAT;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_count_q <= '0;
        end else begin
            pat_q      <= rotate_right(pat_q);
            rx_valid_q <= d_xfer;
            if (d_xfer) begin
                rx_data_q  <= data[PIP_NUM-1];
                rx_count_q <= rx_count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_pipe_chain.sv
// Directed bench: four chains with different sink ready patterns, driven one at
// a time, with an input-side scoreboard checking order and count at the sink.
module tb_handshake_pipe_chain;

    localparam logic [31:0] PATS = {8'hCB, 8'h00, 8'hAA, 8'hFF};

    logic        clk = 1'b0;
    logic        rstDut   [4];
    logic        sValid   [4];
    logic        sReady   [4];
    logic [7:0]  sData    [4];
    logic        rxValid  [4];
    logic [7:0]  rxData   [4];
    logic [31:0] rxCount  [4];

    int          total = 0;
    int          bad = 0;
    int          acceptCnt = 0;
    logic [7:0]  nextData = 8'd2;
    logic [7:0]  expQ [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        handshake_pipe_chain #(
            .DW        (8),
            .PIP_NUM   (5),
            .READY_PAT (PATS[g*8 +: 8])
        ) u_dut (
            .clk      (clk),
            .rst      (rstDut[g]),
            .s_valid  (sValid[g]),
            .s_ready  (sReady[g]),
            .s_data   (sData[g]),
            .rx_valid (rxValid[g]),
            .rx_data  (rxData[g]),
            .rx_count (rxCount[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock of producer activity; data only advances on a handshake.
    task automatic applyStimulus(input int idx, input bit valid);
        bit hs;
        sValid[idx] = valid;
        sData[idx]  = nextData;
        hs = valid && sReady[idx];
        @(posedge clk);
        #1;
        if (hs) begin
            expQ.push_back(nextData);
            nextData = nextData + 8'd2;
            acceptCnt++;
        end
        if (rxValid[idx]) begin
            if (expQ.size() == 0) checkOutput("spurious_rx", 32'd1, 32'd0);
            else                  checkOutput("rx_order", {24'd0, rxData[idx]}, {24'd0, expQ.pop_front()});
        end
    endtask

    task automatic resetDut(input int idx, input bit validDuringReset);
        rstDut[idx] = 1'b1;
        sValid[idx] = validDuringReset;
        sData[idx]  = 8'h5A;
        @(posedge clk);
        #1;
        rstDut[idx] = 1'b0;
        sValid[idx] = 1'b0;
        expQ.delete();
        nextData  = 8'd2;
        acceptCnt = 0;
        checkOutput("rst_s_ready",  {31'd0, sReady[idx]},  32'd1);
        checkOutput("rst_rx_valid", {31'd0, rxValid[idx]}, 32'd0);
        checkOutput("rst_rx_data",  {24'd0, rxData[idx]},  32'd0);
        checkOutput("rst_rx_count", rxCount[idx],          32'd0);
    endtask

    initial begin
        bit expV;
        logic [31:0] dummy;
        for (int i = 0; i < 4; i++) begin
            rstDut[i] = 1'b1;
            sValid[i] = 1'b0;
            sData[i]  = 8'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rstDut[i] = 1'b0;

        $display("[TB] full-rate pattern with a 10-cycle bubble");
        resetDut(0, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(0, (k <= 20) || (k >= 31 && k <= 40));
            expV = (k >= 6 && k <= 25) || (k >= 36 && k <= 45);
            checkOutput($sformatf("ff_rx_valid_step%0d", k), {31'd0, rxValid[0]}, {31'd0, expV});
            checkOutput($sformatf("ff_s_ready_step%0d", k), {31'd0, sReady[0]}, 32'd1);
        end
        checkOutput("ff_accepted", acceptCnt, 32'd30);
        checkOutput("ff_rx_count", rxCount[0], 32'd30);
        checkOutput("ff_last_data", {24'd0, rxData[0]}, 32'd60);

        $display("[TB] alternating pattern, then reset mid-stream");
        resetDut(1, 1'b0);
        for (int k = 1; k <= 40; k++) applyStimulus(1, 1'b1);
        checkOutput("aa_rx_count", rxCount[1], 32'd18);
        checkOutput("aa_count_vs_flight", rxCount[1], acceptCnt - expQ.size());
        checkOutput("aa_inflight_le10", {31'd0, expQ.size() <= 10}, 32'd1);
        resetDut(1, 1'b1);
        for (int k = 1; k <= 40; k++) applyStimulus(1, 1'b1);
        for (int k = 1; k <= 40; k++) applyStimulus(1, 1'b0);
        checkOutput("aa_drained", expQ.size(), 32'd0);
        checkOutput("aa_final_count", rxCount[1], acceptCnt);

        $display("[TB] sink never ready");
        resetDut(2, 1'b0);
        for (int k = 1; k <= 20; k++) applyStimulus(2, 1'b1);
        checkOutput("stall_accepted", acceptCnt, 32'd10);
        checkOutput("stall_s_ready", {31'd0, sReady[2]}, 32'd0);
        checkOutput("stall_rx_count", rxCount[2], 32'd0);
        checkOutput("stall_rx_valid", {31'd0, rxValid[2]}, 32'd0);

        $display("[TB] random source against pattern CB");
        resetDut(3, 1'b0);
        dummy = $urandom(32'd1234);
        for (int k = 1; k <= 200; k++) applyStimulus(3, $urandom_range(0, 3) != 0);
        for (int k = 1; k <= 60; k++) applyStimulus(3, 1'b0);
        checkOutput("rnd_drained", expQ.size(), 32'd0);
        checkOutput("rnd_rx_count", rxCount[3], acceptCnt);
        checkOutput("rnd_some_traffic", {31'd0, acceptCnt > 50}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
